fetch_align_buffer: RTL
=======================

# fetch_align_buffer

Parametrised fetch-stage byte buffer and instruction aligner for the Y86-64 core. It issues aligned multi-byte reads to instruction memory and queues the returned bytes. It decodes instruction length from the head byte and presents one fully aligned instruction per handshake to decode: icode, ifun, rA, rB, valC, valP. Sits between the instruction-memory port and the fetch/decode pipeline register, and replaces fixed 10-byte fetch windows with a streaming buffer that supports PC redirect.

## Interface

Parameters:
- FETCH_BYTES, 8, bytes per memory beat; power of two, 2..16.
- BUF_BYTES, 24, buffer capacity in bytes; must be ≥ FETCH_BYTES+9.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- redirect_valid  in  1  flush buffer and restart fetch at redirect_pc.
- redirect_pc  in  64  new byte PC.
- mem_req_valid  out  1  read request.
- mem_req_addr  out  64  FETCH_BYTES-aligned read address.
- mem_req_ready  in  1  request accepted when high with mem_req_valid.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  8*FETCH_BYTES  byte at addr+k in bits [8k+7:8k].
- mem_rsp_error  in  1  beat is an imem error; data ignored.
- out_valid  out  1  aligned instruction available.
- out_ready  in  1  decode accepts.
- out_pc, out_valP  out  64  instruction PC, PC + length.
- out_icode, out_ifun, out_rA, out_rB  out  4 each.
- out_valC  out  64  little-endian constant; 0 if none.
- out_instr_valid  out  1  icode legal (0x0–0xB).
- out_imem_error  out  1  fetch fault at out_pc.

## Operation

- States: IDLE (after reset; no fetch), RUN, FAULT.
- **Redirect:** any state, highest priority. Sets:
  - fetch_addr = redirect_pc & ~(FETCH_BYTES-1), skip = redirect_pc mod FETCH_BYTES, head_pc = redirect_pc.
  - count = 0, state = RUN.
  - If a response is outstanding, drop = 1.
- **Request rule:** at most one request outstanding. mem_req_valid=1 iff state=RUN, none outstanding, and BUF_BYTES − count ≥ FETCH_BYTES. On accept, fetch_addr += FETCH_BYTES.
- **Response rule:**
  - If drop=1, the beat is discarded and drop clears.
  - Otherwise, if mem_rsp_error=1: no bytes are appended and state = FAULT.
  - Otherwise, bytes skip..FETCH_BYTES-1 are appended in address order, and skip clears to 0.
- **Length by head icode:**
  - 0, 1, 9 → 1
  - 2, 6, A, B → 2
  - 7, 8 → 9
  - 3, 4, 5 → 10
  - illegal → 1, with out_instr_valid=0.
- **Field extraction:** head byte gives icode (high nibble) and ifun (low nibble).
  - Length 2 or 10: byte 1 gives rA (high nibble) and rB (low nibble); otherwise rA = rB = 0xF.
  - valC: bytes 2..9 for length 10, bytes 1..8 for length 9, else 0.
- **out_valid:** 1 when count ≥ 1 and count ≥ length(head).
- **Consume** (out_valid & out_ready): count −= length, buffer shifts by length, head_pc = out_valP.
- **FAULT:**
  - Buffered instructions drain normally.
  - When count < length(head) or count = 0, present one fault instruction: out_valid=1, out_imem_error=1, out_icode=1, out_ifun=0, rA=rB=0xF, out_valC=0, out_valP=out_pc=head_pc.
  - After it is accepted, out_valid=0 until redirect.
- **Same-cycle append and consume:** allowed. The new count is count + appended − consumed and never exceeds BUF_BYTES.

## Timing

- Reset values: state=IDLE, count=0, drop=0, skip=0, mem_req_valid=0, mem_req_addr=0, out_valid=0, all output fields 0 except rA=rB=0xF, out_instr_valid=1, out_imem_error=0.
- Redirect in cycle t → mem_req_valid=1 at t+1 with the aligned address.
- A beat received at t makes its bytes visible on the outputs at t+1.
- Output fields are combinational from registered buffer state; they are stable while out_valid=1 and out_ready=0.
- A handshake in the same cycle as a redirect is void: nothing is consumed, and the flush wins.
- Reset asserted mid-request or mid-response: all state clears; a response arriving after reset is ignored (drop not required; IDLE discards responses).
- Throughput: one instruction per cycle when buffered bytes suffice.

## Test plan

- **Aligned fetch.** Reset, redirect_pc=0x0, memory bytes 30 F2 0A 00 00 00 00 00 00 00 10 00.
  - Expect irmovq: icode 3, rA F, rB 2, valC 0xA, valP 0xA.
  - Then nop at pc 0xA, valP 0xB.
  - Then halt at 0xB.
- **Unaligned redirect.** redirect_pc=0x13 with FETCH_BYTES=8: first request at addr 0x10; bytes 0x10–0x12 are discarded; first out_pc=0x13.
- **Instruction spanning beats.** A 10-byte mrmovq starting at 0x6: out_valid stays 0 until the second beat arrives, then out_valC is assembled correctly across the boundary.
- **Backpressure and full buffer.** Hold out_ready=0.
  - mem_req_valid deasserts once count > BUF_BYTES − FETCH_BYTES.
  - Outputs stay stable.
  - After release, one instruction is consumed per cycle.
- **Redirect with response outstanding.** Request accepted, redirect to 0x40, stale beat returns: the stale beat is dropped and the first out_pc is 0x40 with the correct bytes.
- **Fault and illegal icode.**
  - Head byte 0xC5: out_instr_valid=0, length 1.
  - Error beat after 3 buffered 1-byte instructions: 3 normal outputs, then one imem_error output (icode 1, valP=pc), then out_valid=0 until redirect.

Source files
------------

// File: rtl/fetch_align_buffer.sv
// Fetch-stage byte queue and Y86-64 instruction aligner: streams aligned memory
// beats into a byte buffer and presents one decoded instruction per handshake.
module fetch_align_buffer #(
  parameter int FETCH_BYTES = 8,
  parameter int BUF_BYTES   = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     mem_req_valid,
  output logic [63:0]              mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_rsp_valid,
  input  logic [8*FETCH_BYTES-1:0] mem_rsp_data,
  input  logic                     mem_rsp_error,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_pc,
  output logic [63:0]              out_valP,
  output logic [3:0]               out_icode,
  output logic [3:0]               out_ifun,
  output logic [3:0]               out_rA,
  output logic [3:0]               out_rB,
  output logic [63:0]              out_valC,
  output logic                     out_instr_valid,
  output logic                     out_imem_error
);
  localparam int CNT_W  = $clog2(BUF_BYTES + 1);
  localparam int SKIP_W = $clog2(FETCH_BYTES);
  localparam int BUF_W  = 8 * BUF_BYTES;

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t             state_p0, state_nxt;
  logic [BUF_W-1:0]   buf_p0, buf_nxt;
  logic [CNT_W-1:0]   count_p0, count_nxt;
  logic [63:0]        head_pc_p0, head_pc_nxt;
  logic [63:0]        fetch_addr_p0, fetch_addr_nxt;
  logic [SKIP_W-1:0]  skip_p0, skip_nxt;
  logic               drop_p0, drop_nxt;
  logic               pend_p0, pend_nxt;
  logic               fault_sent_p0, fault_sent_nxt;

  logic [7:0]         b0, b1;
  logic [CNT_W-1:0]   len, cons, base, n_app;
  logic               has_regs, have_instr, in_fault, fault_instr;
  logic               req_fire, rsp_take, app_ok, out_fire;
  logic [BUF_W-1:0]   app_vec;

  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  assign b0          = buf_p0[7:0];
  assign b1          = buf_p0[15:8];
  assign len         = CNT_W'(instr_len(b0[7:4]));
  assign has_regs    = (len == CNT_W'(2)) || (len == CNT_W'(10));
  assign have_instr  = (count_p0 != '0) && (count_p0 >= len);
  assign in_fault    = (state_p0 == FAULT) && !have_instr;
  assign fault_instr = in_fault && !fault_sent_p0;

  assign mem_req_valid = (state_p0 == RUN) && !pend_p0 &&
                         (count_p0 <= CNT_W'(BUF_BYTES - FETCH_BYTES));
  assign mem_req_addr  = fetch_addr_p0;

  assign req_fire = mem_req_valid && mem_req_ready;
  // Responses only count while one is outstanding, so beats arriving after reset are ignored.
  assign rsp_take = mem_rsp_valid && pend_p0;
  assign app_ok   = rsp_take && !drop_p0 && !mem_rsp_error && (state_p0 == RUN);
  assign out_fire = out_valid && out_ready && !redirect_valid;
  assign cons     = (out_fire && !in_fault) ? len : '0;
  assign base     = count_p0 - cons;
  assign n_app    = app_ok ? (CNT_W'(FETCH_BYTES) - CNT_W'(skip_p0)) : '0;
  assign app_vec  = BUF_W'(mem_rsp_data >> {skip_p0, 3'b000});

  always_comb begin
    out_valid       = 1'b0;
    out_pc          = '0;
    out_valP        = '0;
    out_icode       = 4'h0;
    out_ifun        = 4'h0;
    out_rA          = 4'hF;
    out_rB          = 4'hF;
    out_valC        = '0;
    out_instr_valid = 1'b1;
    out_imem_error  = 1'b0;
    if (state_p0 != IDLE) begin
      out_pc = head_pc_p0;
      if (in_fault) begin
        out_valid      = fault_instr;
        out_valP       = head_pc_p0;
        out_icode      = 4'h1;
        out_imem_error = 1'b1;
      end else begin
        out_valid       = have_instr;
        out_valP        = head_pc_p0 + 64'(len);
        out_icode       = b0[7:4];
        out_ifun        = b0[3:0];
        out_instr_valid = (b0[7:4] <= 4'hB);
        if (has_regs) begin
          out_rA = b1[7:4];
          out_rB = b1[3:0];
        end
        if (len == CNT_W'(10))
          out_valC = buf_p0[79:16];
        else if (len == CNT_W'(9))
          out_valC = buf_p0[71:8];
      end
    end
  end

  always_comb begin
    state_nxt      = state_p0;
    head_pc_nxt    = head_pc_p0;
    skip_nxt       = skip_p0;
    drop_nxt       = drop_p0;
    fault_sent_nxt = fault_sent_p0;
    pend_nxt       = (pend_p0 && !mem_rsp_valid) || req_fire;
    fetch_addr_nxt = req_fire ? fetch_addr_p0 + 64'(FETCH_BYTES) : fetch_addr_p0;
    // Consumed bytes shift out at the bottom; new beat lands right above the survivors.
    buf_nxt        = (buf_p0 >> {cons, 3'b000}) |
                     (app_ok ? (app_vec << {base, 3'b000}) : '0);
    count_nxt      = base + n_app;
    if (redirect_valid) begin
      state_nxt      = RUN;
      fetch_addr_nxt = {redirect_pc[63:SKIP_W], {SKIP_W{1'b0}}};
      skip_nxt       = redirect_pc[SKIP_W-1:0];
      head_pc_nxt    = redirect_pc;
      count_nxt      = '0;
      buf_nxt        = '0;
      drop_nxt       = pend_nxt;
      fault_sent_nxt = 1'b0;
    end else begin
      if (rsp_take) begin
        drop_nxt = 1'b0;
        if (!drop_p0 && mem_rsp_error && (state_p0 == RUN))
          state_nxt = FAULT;
        if (app_ok)
          skip_nxt = '0;
      end
      if (out_fire) begin
        if (in_fault)
          fault_sent_nxt = 1'b1;
        else
          head_pc_nxt = out_valP;
      end
    end
  end

  // ---- register stage p0 ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0      <= IDLE;
      count_p0      <= '0;
      head_pc_p0    <= '0;
      fetch_addr_p0 <= '0;
      skip_p0       <= '0;
      drop_p0       <= 1'b0;
      pend_p0       <= 1'b0;
      fault_sent_p0 <= 1'b0;
    end else begin
      state_p0      <= state_nxt;
      count_p0      <= count_nxt;
      head_pc_p0    <= head_pc_nxt;
      fetch_addr_p0 <= fetch_addr_nxt;
      skip_p0       <= skip_nxt;
      drop_p0       <= drop_nxt;
      pend_p0       <= pend_nxt;
      fault_sent_p0 <= fault_sent_nxt;
    end
  end

  always_ff @(posedge clk) begin
    buf_p0 <= buf_nxt;
  end

endmodule
